// File: rtl/noc_pkg.sv
// Shared NoC definitions: route one-hot codes, FSM state encodings and the
// header-flit field offsets used by the input-port buffer.
package noc_pkg;

  // One-hot output-port requests presented to the switch allocator.
  localparam logic [4:0] ROUTE_LOCAL = 5'b00001;
  localparam logic [4:0] ROUTE_EAST  = 5'b00010;
  localparam logic [4:0] ROUTE_WEST  = 5'b00100;
  localparam logic [4:0] ROUTE_NORTH = 5'b01000;
  localparam logic [4:0] ROUTE_SOUTH = 5'b10000;

  // Header layout: destination X occupies [47:44], destination Y [43:40].
  // These offsets track the Noc_parameters header field positions.
  localparam int NOC_DEST_X_LSB = 44;
  localparam int NOC_DEST_Y_LSB = 40;

  // Input framing: waiting for a header, or inside a packet.
  typedef enum logic {
    FRM_WAIT_HEAD = 1'b0,
    FRM_IN_PKT    = 1'b1
  } frame_state_e;

  // Output route: no packet in flight, or holding the route of the packet
  // whose header has already left the buffer.
  typedef enum logic {
    RT_IDLE = 1'b0,
    RT_HOLD = 1'b1
  } route_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count. The head entry is
// kept in a register so it holds its last value when the FIFO drains and
// clears on reset; not-full is registered so it has no path from the pop side.
module noc_flit_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic                     o_not_full,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_not_full;
  logic [WIDTH-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_push       = i_push && r_not_full;
  assign w_pop        = i_pop && (r_count != CW'(0));
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

  // Next head: bypass the incoming word when it lands in the new head slot
  // (FIFO empty after this cycle's pop), otherwise read storage; hold when empty.
  always_comb begin
    w_head_nxt = r_head;
    if (w_count_nxt != CW'(0)) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
        w_head_nxt = i_wdata;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // Storage array write; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, count and registered not-full; pointers wrap modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_not_full <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Registered head word presented on the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
    end else begin
      r_head <= w_head_nxt;
    end
  end

  assign o_not_full = r_not_full;
  assign o_valid    = (r_count != CW'(0));
  assign o_rdata    = r_head;
  assign o_count    = r_count;

endmodule

// File: rtl/noc_input_port_buffer.sv
// Router input port: checks header/body/tail framing, buffers accepted flits
// in an FWFT FIFO and presents a per-flit one-hot XY route request.
module noc_input_port_buffer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int ID_X_WIDTH = 4,
  parameter int ID_Y_WIDTH = 4,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DEST_X_LSB = NOC_DEST_X_LSB,
  parameter int DEST_Y_LSB = NOC_DEST_Y_LSB
) (
  input  logic                    noc_clk,
  input  logic                    noc_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_flit,
  input  logic                    in_is_header,
  input  logic                    in_is_tail,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_flit,
  output logic                    out_is_header,
  output logic                    out_is_tail,
  output logic [4:0]              out_route,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [7:0]              drop_count,
  output logic                    proto_err
);

  localparam logic [ID_X_WIDTH-1:0] MY_X = ID_X_WIDTH'(X_ID);
  localparam logic [ID_Y_WIDTH-1:0] MY_Y = ID_Y_WIDTH'(Y_ID);

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [4:0] xy_route(input logic [ID_X_WIDTH-1:0] dx,
                                          input logic [ID_Y_WIDTH-1:0] dy);
    logic [4:0] rt;
    if (dx > MY_X)      rt = ROUTE_EAST;
    else if (dx < MY_X) rt = ROUTE_WEST;
    else if (dy > MY_Y) rt = ROUTE_NORTH;
    else if (dy < MY_Y) rt = ROUTE_SOUTH;
    else                rt = ROUTE_LOCAL;
    return rt;
  endfunction

  frame_state_e    r_frm_state;
  route_state_e    r_rt_state;
  logic [4:0]      r_route_q;
  logic [7:0]      r_drop_count;
  logic            r_proto_err;

  logic                  w_accept;
  logic                  w_write;
  logic                  w_drop;
  logic                  w_pop;
  logic [DATA_WIDTH+1:0] w_fifo_wdata;
  logic [DATA_WIDTH+1:0] w_fifo_rdata;
  logic                  w_head_hdr;
  logic                  w_head_tail;
  logic [DATA_WIDTH-1:0] w_head_flit;
  logic [4:0]            w_head_route;

  assign w_accept     = in_valid && in_ready;
  // Non-header flits outside a packet are handshaken but discarded.
  assign w_write      = w_accept && ((r_frm_state == FRM_IN_PKT) || in_is_header);
  assign w_drop       = w_accept && (r_frm_state == FRM_WAIT_HEAD) && !in_is_header;
  assign w_pop        = out_valid && out_ready;
  assign w_fifo_wdata = {in_is_header, in_is_tail, in_flit};

  noc_flit_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (noc_clk),
    .i_rst_n    (noc_rst_n),
    .i_push     (w_write),
    .i_wdata    (w_fifo_wdata),
    .i_pop      (w_pop),
    .o_not_full (in_ready),
    .o_valid    (out_valid),
    .o_rdata    (w_fifo_rdata),
    .o_count    (occupancy)
  );

  assign w_head_hdr   = w_fifo_rdata[DATA_WIDTH+1];
  assign w_head_tail  = w_fifo_rdata[DATA_WIDTH];
  assign w_head_flit  = w_fifo_rdata[DATA_WIDTH-1:0];
  assign w_head_route = xy_route(w_head_flit[DEST_X_LSB +: ID_X_WIDTH],
                                 w_head_flit[DEST_Y_LSB +: ID_Y_WIDTH]);

  // Framing FSM with saturating drop counter and sticky protocol-error flag.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_frm_state  <= FRM_WAIT_HEAD;
      r_drop_count <= 8'd0;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
      if (w_accept && (r_frm_state == FRM_IN_PKT) && in_is_header) begin
        r_proto_err <= 1'b1;
      end
      if (w_write) begin
        r_frm_state <= in_is_tail ? FRM_WAIT_HEAD : FRM_IN_PKT;
      end
    end
  end

  // Route FSM: capture the route when a header leaves, release it with the tail.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_rt_state <= RT_IDLE;
      r_route_q  <= '0;
    end else if (w_pop) begin
      if (w_head_tail) begin
        r_rt_state <= RT_IDLE;
        r_route_q  <= '0;
      end else if (w_head_hdr) begin
        r_rt_state <= RT_HOLD;
        r_route_q  <= w_head_route;
      end
    end
  end

  // Per-flit route request: live for headers, held for body/tail, 0 when empty.
  always_comb begin
    out_route = '0;
    if (out_valid) begin
      if (w_head_hdr) begin
        out_route = w_head_route;
      end else if (r_rt_state == RT_HOLD) begin
        out_route = r_route_q;
      end
    end
  end

  assign out_flit      = w_head_flit;
  assign out_is_header = w_head_hdr;
  assign out_is_tail   = w_head_tail;
  assign drop_count    = r_drop_count;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_noc_input_port_buffer.sv
// Testbench for noc_input_port_buffer (X_ID=1, Y_ID=1, DEPTH=4): a queue-based
// packet model checked every cycle, a route vector table and directed corners.
module tb_noc_input_port_buffer;

  localparam int DEPTH = 4;
  localparam int XID   = 1;
  localparam int YID   = 1;
  localparam logic [4:0] R_LOCAL = 5'b00001;
  localparam logic [4:0] R_EAST  = 5'b00010;
  localparam logic [4:0] R_WEST  = 5'b00100;
  localparam logic [4:0] R_NORTH = 5'b01000;
  localparam logic [4:0] R_SOUTH = 5'b10000;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_flit;
  logic        in_is_header;
  logic        in_is_tail;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_flit;
  logic        out_is_header;
  logic        out_is_tail;
  logic [4:0]  out_route;
  logic [2:0]  occupancy;
  logic [7:0]  drop_count;
  logic        proto_err;

  always #5 noc_clk = ~noc_clk;

  noc_input_port_buffer #(
    .DATA_WIDTH (64),
    .DEPTH      (DEPTH),
    .ID_X_WIDTH (4),
    .ID_Y_WIDTH (4),
    .X_ID       (XID),
    .Y_ID       (YID),
    .DEST_X_LSB (44),
    .DEST_Y_LSB (40)
  ) dut (
    .noc_clk       (noc_clk),
    .noc_rst_n     (noc_rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flit       (in_flit),
    .in_is_header  (in_is_header),
    .in_is_tail    (in_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .out_route     (out_route),
    .occupancy     (occupancy),
    .drop_count    (drop_count),
    .proto_err     (proto_err)
  );

  typedef struct {
    logic [63:0] flit;
    bit          hdr;
    bit          tail;
  } flit_t;

  typedef struct {
    logic [3:0] dx;
    logic [3:0] dy;
    logic [4:0] exp_route;
  } vec_t;

  // Reference model state: buffered flits in order, packet framing flag,
  // drop tally, sticky error, route of the packet in flight, last head shown.
  flit_t      m_q[$];
  bit         m_in_pkt;
  int         m_drop;
  bit         m_perr;
  logic [4:0] m_pkt_route;
  flit_t      m_last;

  int checks = 0;
  int errors = 0;

  function automatic logic [4:0] ref_route(input logic [63:0] f);
    int dx, dy;
    dx = int'(f[47:44]);
    dy = int'(f[43:40]);
    if (dx > XID) return R_EAST;
    if (dx < XID) return R_WEST;
    if (dy > YID) return R_NORTH;
    if (dy < YID) return R_SOUTH;
    return R_LOCAL;
  endfunction

  function automatic logic [63:0] mk_flit(input int dx, input int dy);
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[47:44] = 4'(dx);
    f[43:40] = 4'(dy);
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_pkt    = 1'b0;
    m_drop      = 0;
    m_perr      = 1'b0;
    m_pkt_route = 5'b0;
    m_last.flit = 64'h0;
    m_last.hdr  = 1'b0;
    m_last.tail = 1'b0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit    acc, pop;
    flit_t h, n;
    acc = in_valid && (m_q.size() != DEPTH);
    pop = (m_q.size() != 0) && out_ready;
    if (pop) begin
      h = m_q.pop_front();
      if (h.tail)     m_pkt_route = 5'b0;
      else if (h.hdr) m_pkt_route = ref_route(h.flit);
    end
    if (acc) begin
      if (!m_in_pkt && !in_is_header) begin
        if (m_drop < 255) m_drop++;
      end else begin
        if (m_in_pkt && in_is_header) m_perr = 1'b1;
        n.flit = in_flit;
        n.hdr  = in_is_header;
        n.tail = in_is_tail;
        m_q.push_back(n);
        m_in_pkt = !in_is_tail;
      end
    end
    if (m_q.size() != 0) m_last = m_q[0];
  endtask

  task automatic check_all();
    logic [4:0] er;
    er = 5'b0;
    if (m_q.size() != 0) er = m_q[0].hdr ? ref_route(m_q[0].flit) : m_pkt_route;
    chk("in_ready",      in_ready,      64'(m_q.size() != DEPTH));
    chk("out_valid",     out_valid,     64'(m_q.size() != 0));
    chk("out_flit",      out_flit,      m_last.flit);
    chk("out_is_header", out_is_header, 64'(m_last.hdr));
    chk("out_is_tail",   out_is_tail,   64'(m_last.tail));
    chk("out_route",     out_route,     64'(er));
    chk("occupancy",     occupancy,     64'(m_q.size()));
    chk("drop_count",    drop_count,    64'(m_drop));
    chk("proto_err",     proto_err,     64'(m_perr));
  endtask

  task automatic tick();
    model_edge();
    @(posedge noc_clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [63:0] f, input logic h, input logic t);
    in_valid     = v;
    in_flit      = f;
    in_is_header = h;
    in_is_tail   = t;
  endtask

  task automatic send(input logic [63:0] f, input logic h, input logic t);
    drive(1'b1, f, h, t);
    tick();
  endtask

  task automatic idle(input int n);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    repeat (2) @(posedge noc_clk);
    #1;
    model_reset();
    check_all();
    noc_rst_n = 1'b1;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{4'd3, 4'd0, R_EAST};
    vt[1] = '{4'd0, 4'd1, R_WEST};
    vt[2] = '{4'd1, 4'd3, R_NORTH};
    vt[3] = '{4'd1, 4'd0, R_SOUTH};
    vt[4] = '{4'd1, 4'd1, R_LOCAL};
    vt[5] = '{4'd0, 4'd9, R_WEST};
    vt[6] = '{4'd2, 4'd0, R_EAST};

    // Reset values
    do_reset();
    chk("rst_in_ready", in_ready, 64'd1);
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_out_flit", out_flit, 64'd0);
    chk("rst_route", out_route, 64'd0);
    chk("rst_occ", occupancy, 64'd0);
    chk("rst_drop", drop_count, 64'd0);
    chk("rst_perr", proto_err, 64'd0);

    // Three-flit EAST packet, back-to-back, downstream always ready
    out_ready = 1'b1;
    send(mk_flit(3, 0), 1'b1, 1'b0);
    chk("east_hdr_valid", out_valid, 64'd1);
    chk("east_hdr_route", out_route, 64'(R_EAST));
    chk("east_hdr_occ", 64'(occupancy <= 3'd1), 64'd1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    chk("east_body_flit", out_flit, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("east_body_route", out_route, 64'(R_EAST));
    chk("east_body_occ", 64'(occupancy <= 3'd1), 64'd1);
    send(mk_flit(0, 0), 1'b0, 1'b1);
    chk("east_tail_route", out_route, 64'(R_EAST));
    chk("east_tail_occ", 64'(occupancy <= 3'd1), 64'd1);
    idle(1);
    chk("east_empty_route", out_route, 64'd0);

    // Route table: single-flit packets
    for (int i = 0; i < 7; i++) begin
      send(mk_flit(int'(vt[i].dx), int'(vt[i].dy)), 1'b1, 1'b1);
      chk($sformatf("route_vec%0d", i), out_route, 64'(vt[i].exp_route));
      idle(1);
    end

    // Full FIFO: five offered flits with downstream stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(mk_flit(2, 1), (i == 0), 1'b0);
      if (i == 3) begin
        chk("full_occ", occupancy, 64'd4);
        chk("full_in_ready", in_ready, 64'd0);
      end
    end
    chk("full_hold_occ", occupancy, 64'd4);
    out_ready = 1'b1;
    tick();
    chk("pop_occ", occupancy, 64'd3);
    chk("pop_in_ready", in_ready, 64'd1);
    out_ready = 1'b0;
    tick();
    chk("refill_occ", occupancy, 64'd4);
    out_ready = 1'b1;
    send(mk_flit(0, 0), 1'b0, 1'b1);
    idle(6);

    // Second header before a tail: sticky proto_err, new packet keeps its own route
    send(mk_flit(0, 1), 1'b1, 1'b0);
    send(mk_flit(0, 0), 1'b0, 1'b0);
    send(mk_flit(3, 1), 1'b1, 1'b0);
    chk("perr_set", proto_err, 64'd1);
    chk("perr_pkt2_route", out_route, 64'(R_EAST));
    send(mk_flit(0, 0), 1'b0, 1'b0);
    chk("perr_pkt2_body_route", out_route, 64'(R_EAST));
    send(mk_flit(0, 0), 1'b0, 1'b1);
    idle(3);
    chk("perr_sticky", proto_err, 64'd1);

    // Asynchronous reset mid-packet with three flits buffered
    out_ready = 1'b0;
    send(mk_flit(0, 2), 1'b1, 1'b0);
    send(mk_flit(0, 0), 1'b0, 1'b0);
    send(mk_flit(0, 0), 1'b0, 1'b0);
    idle(1);
    chk("prerst_occ", occupancy, 64'd3);
    #2;
    noc_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_occ", occupancy, 64'd0);
    chk("arst_out_valid", out_valid, 64'd0);
    chk("arst_in_ready", in_ready, 64'd1);
    chk("arst_perr", proto_err, 64'd0);
    @(posedge noc_clk);
    #1;
    check_all();
    noc_rst_n = 1'b1;

    // Body flits while waiting for a header are dropped; counter saturates
    out_ready = 1'b1;
    send(mk_flit(0, 0), 1'b0, 1'b0);
    chk("drop_first", drop_count, 64'd1);
    chk("drop_no_valid", out_valid, 64'd0);
    for (int i = 0; i < 299; i++) send(mk_flit(0, 0), 1'b0, (i % 3) == 0);
    chk("drop_saturate", drop_count, 64'd255);
    idle(1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      drive(1'($urandom_range(0, 1)),
            mk_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
            (r < 3), (r >= 2 && r < 6));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    idle(DEPTH + 2);
    chk("rand_drained", occupancy, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
